// File: rtl/rio_link_pkg.sv
// Shared constants for the N-byte RocketIO link receive controller:
// K-character codes and the one-hot receive state encoding.
package rio_link_pkg;

    localparam logic [7:0] K_SYN = 8'hF7;
    localparam logic [7:0] K_SOP = 8'hFD;
    localparam logic [7:0] K_EOP = 8'hFE;

    localparam int unsigned ST_W = 7;

    typedef enum logic [ST_W-1:0] {
        ST_INIT  = 7'b000_0001,
        ST_SYNC  = 7'b000_0010,
        ST_IDLE  = 7'b000_0100,
        ST_START = 7'b000_1000,
        ST_SOP   = 7'b001_0000,
        ST_DATA  = 7'b010_0000,
        ST_ERROR = 7'b100_0000
    } rx_state_t;

    // States in which the link counts as up
    function automatic logic state_is_up(input rx_state_t s);
        return (s == ST_IDLE) || (s == ST_START) || (s == ST_SOP) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/rio_link_rx_init_timer.sv
// Link stability timer: counts up while enabled, done once bit CNT_BIT is set.
// Saturates at done so a long INIT stay never wraps back to not-done.
module rio_link_rx_init_timer #(
    parameter int unsigned CNT_BIT = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_done
);

    localparam int unsigned CNT_W = CNT_BIT + 1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !r_cnt[CNT_BIT]) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done = r_cnt[CNT_BIT];

endmodule

// File: rtl/rio_link_rx_ctrl_nb.sv
// N-byte RocketIO link receive controller: bring-up, SOP/EOP framing, credits, error stats.
// Optional RIO_RX_AUTO_RESYNC_EN: leave ERROR after RESYNC_HOLD quiet cycles and re-init.
module rio_link_rx_ctrl_nb
    import rio_link_pkg::*;
#(
    parameter int unsigned BYTES         = 2,
    parameter int unsigned CREDIT_WIDTH  = 16,
    parameter int unsigned INIT_CNT_BIT  = 12,
    parameter int unsigned MAX_PKT_WORDS = 256,
    parameter int unsigned ERR_CNT_WIDTH = 8,
    parameter int unsigned RESYNC_HOLD   = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_link_error,
    input  logic [8*BYTES-1:0]       i_rio_rx_data,
    input  logic [BYTES-1:0]         i_rio_rx_isk,
    output logic                     o_link_up,
    output logic                     o_link_sync,
    output logic                     o_link_err,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic [CREDIT_WIDTH-1:0]  o_ds_credit,
    output logic                     o_ds_credit_valid,
    output logic                     o_rx_valid,
    output logic                     o_rx_sop,
    output logic                     o_rx_eop,
    output logic                     o_rx_abort,
    output logic [8*BYTES-1:0]       o_rx_data
);

    localparam int unsigned DATA_WIDTH = 8 * BYTES;
    localparam int unsigned WCNT_W     = $clog2(MAX_PKT_WORDS + 1);

    if ((BYTES != 2) && (BYTES != 4)) begin : g_bad_bytes
        $error("BYTES must be 2 or 4");
    end
    if (CREDIT_WIDTH > DATA_WIDTH) begin : g_bad_credit
        $error("CREDIT_WIDTH exceeds the data width");
    end
    if (RESYNC_HOLD == 0) begin : g_bad_hold
        $error("RESYNC_HOLD must be at least 1");
    end

    rx_state_t               r_state;
    rx_state_t               w_next_state;
    logic [DATA_WIDTH-1:0]   r_data_q;
    logic [BYTES-1:0]        r_isk_q;
    logic [WCNT_W-1:0]       r_word_cnt;
    logic                    w_is_syn, w_is_sop, w_is_eop, w_word_last;
    logic                    w_init_done, w_init_inc, w_init_clr, w_resync;

    logic                    r_link_up, r_link_err, r_credit_valid;
    logic                    r_rx_valid, r_rx_sop, r_rx_eop, r_rx_abort;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [CREDIT_WIDTH-1:0] r_ds_credit;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    w_link_up, w_link_err, w_err_entry, w_in_pkt, w_credit_valid;
    logic                    w_rx_valid, w_rx_sop, w_rx_eop, w_rx_abort;

    // Framing decisions are made on the registered word so flags line up with o_rx_data
    assign w_is_syn    = r_isk_q[BYTES-1] && (r_data_q[DATA_WIDTH-1 -: 8] == K_SYN);
    assign w_is_sop    = r_isk_q[BYTES-1] && (r_data_q[DATA_WIDTH-1 -: 8] == K_SOP);
    assign w_is_eop    = r_isk_q[BYTES-1] && (r_data_q[DATA_WIDTH-1 -: 8] == K_EOP);
    assign w_word_last = (r_word_cnt + WCNT_W'(1)) == WCNT_W'(MAX_PKT_WORDS);

    assign w_init_inc = (r_state == ST_INIT) && !i_link_error;
    assign w_init_clr = (((r_state == ST_INIT) || (r_state == ST_SYNC)) && i_link_error) || w_resync;

    rio_link_rx_init_timer #(
        .CNT_BIT (INIT_CNT_BIT)
    ) u_init_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_init_inc),
        .i_clr  (w_init_clr),
        .o_done (w_init_done)
    );

`ifdef RIO_RX_AUTO_RESYNC_EN
    localparam int unsigned HOLD_W = $clog2(RESYNC_HOLD + 1);

    logic [HOLD_W-1:0] r_hold_cnt;

    assign w_resync = (r_state == ST_ERROR) && !i_link_error
                      && (r_hold_cnt == HOLD_W'(RESYNC_HOLD - 1));

    // Any link error while holding restarts the quiet period
    always_ff @(posedge clk) begin
        if (!rst_n || (r_state != ST_ERROR) || i_link_error) begin
            r_hold_cnt <= '0;
        end else if (!w_resync) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign w_resync = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_link_up && i_link_error) begin
            w_next_state = ST_ERROR;
        end else begin
            case (r_state)
                ST_INIT:  if (w_init_done && !i_link_error) w_next_state = ST_SYNC;
                ST_SYNC: begin
                    if (i_link_error)  w_next_state = ST_INIT;
                    else if (w_is_syn) w_next_state = ST_IDLE;
                end
                ST_IDLE:  if (w_is_sop) w_next_state = ST_START;
                ST_START: w_next_state = ST_SOP;
                ST_SOP:   w_next_state = w_is_eop ? ST_IDLE : ST_DATA;
                ST_DATA: begin
                    if (w_is_eop)         w_next_state = ST_IDLE;
                    else if (w_is_sop)    w_next_state = ST_ERROR;
                    else if (w_word_last) w_next_state = ST_ERROR;
                end
                ST_ERROR: if (w_resync) w_next_state = ST_INIT;
                default:  w_next_state = ST_INIT;
            endcase
        end
    end

    // Next values of the registered outputs; a packet word that trips ERROR becomes an abort
    always_comb begin
        w_link_up      = state_is_up(w_next_state);
        w_link_err     = (w_next_state == ST_ERROR);
        w_err_entry    = w_link_err && (r_state != ST_ERROR);
        w_in_pkt       = (r_state == ST_SOP) || (r_state == ST_DATA);
        w_rx_valid     = w_in_pkt && !w_err_entry;
        w_rx_sop       = (r_state == ST_SOP) && !w_err_entry;
        w_rx_eop       = w_in_pkt && w_is_eop && !w_err_entry;
        w_rx_abort     = w_in_pkt && w_err_entry;
        w_credit_valid = (r_state == ST_IDLE) && (r_isk_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_q       <= '0;
            r_isk_q        <= '0;
            r_word_cnt     <= '0;
            r_link_up      <= 1'b0;
            r_link_err     <= 1'b0;
            r_credit_valid <= 1'b0;
            r_ds_credit    <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_sop       <= 1'b0;
            r_rx_eop       <= 1'b0;
            r_rx_abort     <= 1'b0;
            r_rx_data      <= '0;
            r_err_cnt      <= '0;
        end else begin
            r_data_q       <= i_rio_rx_data;
            r_isk_q        <= i_rio_rx_isk;
            r_link_up      <= w_link_up;
            r_link_err     <= w_link_err;
            r_credit_valid <= w_credit_valid;
            r_rx_valid     <= w_rx_valid;
            r_rx_sop       <= w_rx_sop;
            r_rx_eop       <= w_rx_eop;
            r_rx_abort     <= w_rx_abort;
            r_rx_data      <= r_data_q;
            if (r_state == ST_START) begin
                r_word_cnt <= '0;
            end else if (w_in_pkt) begin
                r_word_cnt <= r_word_cnt + WCNT_W'(1);
            end
            if (w_credit_valid) begin
                r_ds_credit <= r_data_q[CREDIT_WIDTH-1:0];
            end
            if (w_err_entry && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign o_link_up         = r_link_up;
    assign o_link_sync       = (r_state == ST_SYNC);
    assign o_link_err        = r_link_err;
    assign o_err_cnt         = r_err_cnt;
    assign o_ds_credit       = r_ds_credit;
    assign o_ds_credit_valid = r_credit_valid;
    assign o_rx_valid        = r_rx_valid;
    assign o_rx_sop          = r_rx_sop;
    assign o_rx_eop          = r_rx_eop;
    assign o_rx_abort        = r_rx_abort;
    assign o_rx_data         = r_rx_data;

endmodule
